rtc_pps_alarm: RTL
==================

// Module: rtc_pps_alarm
// PURPOSE
//  Downstream consumer of the RTC time outputs (time_reg_ns/time_reg_sec). Generates a
//  1PPS pulse on every natural second rollover and a one-shot time alarm: fires when RTC
//  time reaches a programmed {sec,ns} target. Feeds board PPS pin and CPU interrupt logic.
// PARAMETERS
//  NS_PER_SEC   30'd1000000000  ns field limit; alarm_ns_in >= this is rejected
//  PPS_W_DEF    32'd8           pulse width (clk cycles) used while pps_width_in==0
// PORTS
//  rst            in   1   asynchronous reset, active-high
//  clk            in   1   clock, same domain as RTC
//  time_reg_ns    in   38  RTC time, 37:8 ns, 7:0 ns_fraction (fraction ignored)
//  time_reg_sec   in   48  RTC seconds
//  pps_en         in   1   1 = PPS generation enabled
//  pps_width_in   in   32  PPS high time in clk cycles; 0 -> PPS_W_DEF
//  pps_out        out  1   PPS pulse
//  alarm_ld       in   1   1-cycle strobe: load target and arm
//  alarm_sec_in   in   48  target seconds
//  alarm_ns_in    in   30  target ns
//  alarm_clr      in   1   1-cycle strobe: disarm, clear irq/late
//  alarm_armed    out  1   state==ARMED
//  alarm_irq      out  1   level, set on fire, held until alarm_clr or alarm_ld
//  alarm_late     out  1   target was already in the past when armed
//  alarm_err      out  1   1-cycle pulse: alarm_ld rejected (ns out of range)
// BEHAVIOUR
//  Reset: all outputs 0; alarm FSM IDLE; target 0; sec_prev_vld 0; pps counter 0.
//  PPS: register sec_prev <= time_reg_sec each cycle; sec_prev_vld set 1 cycle after reset.
//   - rollover := sec_prev_vld && time_reg_sec == sec_prev+1 (48-bit add, wraps to 0).
//   - rollover && pps_en in cycle N -> pps_out=1 from N+1 for W cycles, W = pps_width_in
//     sampled in cycle N (0 -> PPS_W_DEF). Down-counter, 32-bit.
//   - any other sec change (time_ld jump, backwards, +2 or more) -> no pulse.
//   - rollover while pulse active -> counter restarts with new W, pps_out stays high.
//   - pps_en deasserted mid-pulse -> pulse completes; no new pulses start.
//  Alarm compare: reached := {time_reg_sec, time_reg_ns[37:8]} >= {tgt_sec, tgt_ns},
//   78-bit unsigned compare on current input; fraction bits ignored.
//  Alarm FSM (IDLE, ARMED, FIRED):
//   - alarm_ld with alarm_ns_in < NS_PER_SEC: latch target, -> ARMED, irq=0, late=0,
//     first_chk=1. Accepted from any state.
//   - alarm_ld with alarm_ns_in >= NS_PER_SEC: alarm_err=1 next cycle; state/target unchanged.
//   - ARMED && reached -> FIRED; alarm_irq=1 the cycle after reached is observed
//     (1-cycle latency from the RTC time update). If first_chk was set in that cycle,
//     alarm_late=1 too. first_chk clears after the first ARMED cycle.
//   - FIRED: holds irq until alarm_clr (-> IDLE) or alarm_ld (re-arm).
//   - alarm_clr from any state -> IDLE, irq=0, late=0.
//   - alarm_clr && alarm_ld same cycle: alarm_clr wins; load ignored, no alarm_err.
//   - Backwards time_ld while ARMED: no special case; compare simply re-evaluates.
//  alarm_armed = (state==ARMED). Single one-shot: no auto re-arm.
//  Reset asserted mid-pulse or while ARMED: everything returns to reset values immediately.
// TESTING
//  1 pps_en=1, pps_width_in=4; sec 5->6 at cycle N -> pps_out=1 cycles N+1..N+4, 0 at N+5.
//  2 time_ld style jump sec 6->100, then 100->101 -> no pulse at jump, 4-cycle pulse at 101.
//  3 pps_width_in=0 -> 8-cycle pulse; second rollover at pulse cycle 3 -> high 8 more cycles.
//  4 arm 10 s / 500 ns at time 9 s; ns ramps 496,500 in sec 10 -> irq=1 cycle after 500,
//    late=0, armed=0; irq held until alarm_clr, then irq=0.
//  5 arm 3 s / 0 ns while time=7 s -> irq=1 and late=1 two cycles after alarm_ld;
//    alarm_ns_in=1000000000 -> alarm_err pulse, state unchanged.
//  6 alarm_ld && alarm_clr same cycle while ARMED -> IDLE, target unchanged; reset mid-pulse
//    -> pps_out=0 during reset, no pulse on first cycle after release.

Source files
------------

// File: rtl/rtc_pps_alarm_if.sv
// rtl/rtc_pps_alarm_if.sv - RTC time, PPS and alarm signal bundle
// Purpose: carries RTC time inputs, PPS control/output and alarm control/status.
// master: drives time, PPS control and alarm strobes; observes pps_out and alarm status.
// slave : the rtc_pps_alarm block.
interface rtc_pps_alarm_if;
    logic [37:0] time_reg_ns;
    logic [47:0] time_reg_sec;
    logic        pps_en;
    logic [31:0] pps_width_in;
    logic        pps_out;
    logic        alarm_ld;
    logic [47:0] alarm_sec_in;
    logic [29:0] alarm_ns_in;
    logic        alarm_clr;
    logic        alarm_armed;
    logic        alarm_irq;
    logic        alarm_late;
    logic        alarm_err;

    modport master (
        output time_reg_ns, time_reg_sec, pps_en, pps_width_in,
        output alarm_ld, alarm_sec_in, alarm_ns_in, alarm_clr,
        input  pps_out, alarm_armed, alarm_irq, alarm_late, alarm_err
    );

    modport slave (
        input  time_reg_ns, time_reg_sec, pps_en, pps_width_in,
        input  alarm_ld, alarm_sec_in, alarm_ns_in, alarm_clr,
        output pps_out, alarm_armed, alarm_irq, alarm_late, alarm_err
    );
endinterface

// File: rtl/rtc_pps_alarm.sv
// rtl/rtc_pps_alarm.sv - 1PPS generator and one-shot time alarm driven by RTC time
// Purpose: pulses pps_out for a programmable number of cycles on every +1 second step
//   of the RTC, and raises a one-shot alarm when RTC time reaches a {sec,ns} target.
// Ports: clk, rst (async, active-high); bus (slave) carries time_reg_ns/time_reg_sec,
//   pps_en/pps_width_in/pps_out, alarm_ld/alarm_sec_in/alarm_ns_in/alarm_clr and
//   alarm_armed/alarm_irq/alarm_late/alarm_err.
module rtc_pps_alarm #(
    parameter logic [29:0] NS_PER_SEC = 30'd1000000000,
    parameter logic [31:0] PPS_W_DEF  = 32'd8
) (
    input  logic          clk,
    input  logic          rst,
    rtc_pps_alarm_if.slave bus
);
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ARMED = 2'd1;
    localparam logic [1:0] ST_FIRED = 2'd2;

    logic [47:0] sec_prev_q, sec_prev_d;
    logic        sec_prev_vld_q, sec_prev_vld_d;
    logic [31:0] pps_cnt_q, pps_cnt_d;
    logic [1:0]  state_q, state_d;
    logic [47:0] tgt_sec_q, tgt_sec_d;
    logic [29:0] tgt_ns_q, tgt_ns_d;
    logic        irq_q, irq_d;
    logic        late_q, late_d;
    logic        err_q, err_d;
    logic        first_chk_q, first_chk_d;

    logic        rollover;
    logic        reached;
    logic        ld_ok;
    logic [31:0] pps_w;
    logic        unused_frac;

    // Sub-ns fraction never participates in any decision.
    assign unused_frac = ^bus.time_reg_ns[7:0];

    // PPS: only an exact +1 second step counts; jumps and backward steps are ignored.
    always_comb begin
        rollover       = sec_prev_vld_q && (bus.time_reg_sec == sec_prev_q + 48'd1);
        pps_w          = (bus.pps_width_in == 32'd0) ? PPS_W_DEF : bus.pps_width_in;
        sec_prev_d     = bus.time_reg_sec;
        sec_prev_vld_d = 1'b1;
        pps_cnt_d      = pps_cnt_q;
        if (rollover && bus.pps_en) begin
            pps_cnt_d = pps_w;
        end else if (pps_cnt_q != 32'd0) begin
            pps_cnt_d = pps_cnt_q - 32'd1;
        end
    end

    // Alarm FSM. Priority: clear, then valid load, then the normal compare.
    // A rejected load only raises err; the FSM keeps running as if no load came.
    always_comb begin
        reached     = {bus.time_reg_sec, bus.time_reg_ns[37:8]} >= {tgt_sec_q, tgt_ns_q};
        ld_ok       = bus.alarm_ns_in < NS_PER_SEC;
        state_d     = state_q;
        tgt_sec_d   = tgt_sec_q;
        tgt_ns_d    = tgt_ns_q;
        irq_d       = irq_q;
        late_d      = late_q;
        err_d       = 1'b0;
        first_chk_d = first_chk_q;
        if (bus.alarm_clr) begin
            state_d     = ST_IDLE;
            irq_d       = 1'b0;
            late_d      = 1'b0;
            first_chk_d = 1'b0;
        end else if (bus.alarm_ld && ld_ok) begin
            state_d     = ST_ARMED;
            tgt_sec_d   = bus.alarm_sec_in;
            tgt_ns_d    = bus.alarm_ns_in;
            irq_d       = 1'b0;
            late_d      = 1'b0;
            first_chk_d = 1'b1;
        end else begin
            err_d = bus.alarm_ld;
            case (state_q)
                ST_ARMED: begin
                    if (reached) begin
                        state_d = ST_FIRED;
                        irq_d   = 1'b1;
                        late_d  = first_chk_q;
                    end
                    first_chk_d = 1'b0;
                end
                ST_IDLE, ST_FIRED: ;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sec_prev_q     <= 48'd0;
            sec_prev_vld_q <= 1'b0;
            pps_cnt_q      <= 32'd0;
            state_q        <= ST_IDLE;
            tgt_sec_q      <= 48'd0;
            tgt_ns_q       <= 30'd0;
            irq_q          <= 1'b0;
            late_q         <= 1'b0;
            err_q          <= 1'b0;
            first_chk_q    <= 1'b0;
        end else begin
            sec_prev_q     <= sec_prev_d;
            sec_prev_vld_q <= sec_prev_vld_d;
            pps_cnt_q      <= pps_cnt_d;
            state_q        <= state_d;
            tgt_sec_q      <= tgt_sec_d;
            tgt_ns_q       <= tgt_ns_d;
            irq_q          <= irq_d;
            late_q         <= late_d;
            err_q          <= err_d;
            first_chk_q    <= first_chk_d;
        end
    end

    assign bus.pps_out     = (pps_cnt_q != 32'd0);
    assign bus.alarm_armed = (state_q == ST_ARMED);
    assign bus.alarm_irq   = irq_q;
    assign bus.alarm_late  = late_q;
    assign bus.alarm_err   = err_q;
endmodule
